// File: rtl/vscale_mem_arbiter.sv
// Shares one single-outstanding memory port between the vscale fetch (imem) and
// data (dmem) interfaces: alignment check, dmem-priority arbitration, handshake.
module vscale_mem_arbiter #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_DMEM_STREAK = 4
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic                  imem_req,
   input  logic [ADDR_WIDTH-1:0] imem_addr,
   output logic                  imem_wait,
   output logic [DATA_WIDTH-1:0] imem_rdata,
   output logic                  imem_badmem_e,

   input  logic                  dmem_req,
   input  logic                  dmem_wen,
   input  logic [2:0]            dmem_size,
   input  logic [ADDR_WIDTH-1:0] dmem_addr,
   input  logic [DATA_WIDTH-1:0] dmem_wdata,
   output logic                  dmem_wait,
   output logic [DATA_WIDTH-1:0] dmem_rdata,
   output logic                  dmem_badmem_e,

   output logic                  mem_req,
   output logic                  mem_wen,
   output logic [2:0]            mem_size,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ready,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_error
);

   localparam int STREAK_W = $clog2(MAX_DMEM_STREAK + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DMEM_STREAK);
   localparam logic [2:0] SIZE_WORD = 3'b010;

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;
   typedef enum logic {OWN_IMEM, OWN_DMEM} owner_t;

   state_t                state_reg, state_next;
   owner_t                owner_reg, owner_next;
   logic [ADDR_WIDTH-1:0] fetch_addr_reg, fetch_addr_next;
   logic [STREAK_W-1:0]   streak_reg, streak_next;
   logic                  mem_req_reg, mem_req_next;
   logic                  mem_wen_reg, mem_wen_next;
   logic [2:0]            mem_size_reg, mem_size_next;
   logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
   logic [DATA_WIDTH-1:0] mem_wdata_reg, mem_wdata_next;

   logic idle;
   logic imem_misaligned, dmem_misaligned;
   logic imem_bad, dmem_bad, imem_ok, dmem_ok;
   logic grant_imem, grant_dmem;
   logic resp_done, fetch_match;
   logic imem_resp_done, dmem_resp_done;
   logic imem_done, dmem_done;

   assign idle = (state_reg == ST_IDLE);

   always_comb begin
      imem_misaligned = (imem_addr[1:0] != 2'b00);
      case (dmem_size[1:0])
         2'd0:    dmem_misaligned = 1'b0;
         2'd1:    dmem_misaligned = dmem_addr[0];
         2'd2:    dmem_misaligned = (dmem_addr[1:0] != 2'b00);
         default: dmem_misaligned = 1'b1;
      endcase
   end

   assign imem_bad = idle && imem_req && imem_misaligned;
   assign dmem_bad = idle && dmem_req && dmem_misaligned;
   assign imem_ok  = idle && imem_req && !imem_misaligned;
   assign dmem_ok  = idle && dmem_req && !dmem_misaligned;

   // dmem wins by default; a saturated streak hands one grant to a waiting fetch
   assign grant_imem = imem_ok && (!dmem_ok || (streak_reg == STREAK_MAX));
   assign grant_dmem = dmem_ok && !grant_imem;

   // A fetch response only counts if the core still wants that same address
   assign resp_done      = (state_reg == ST_RESP) && mem_rvalid;
   assign fetch_match    = imem_req && (imem_addr == fetch_addr_reg);
   assign imem_resp_done = resp_done && (owner_reg == OWN_IMEM) && fetch_match;
   assign dmem_resp_done = resp_done && (owner_reg == OWN_DMEM);

   assign imem_done = reset && (imem_bad || imem_resp_done);
   assign dmem_done = reset && (dmem_bad || dmem_resp_done);

   assign imem_wait     = imem_req && !imem_done;
   assign dmem_wait     = dmem_req && !dmem_done;
   assign imem_badmem_e = imem_done && (imem_bad || mem_error);
   assign dmem_badmem_e = dmem_done && (dmem_bad || mem_error);
   assign imem_rdata    = mem_rdata;
   assign dmem_rdata    = mem_rdata;

   assign mem_req   = mem_req_reg;
   assign mem_wen   = mem_wen_reg;
   assign mem_size  = mem_size_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_wdata = mem_wdata_reg;

   always_comb begin
      state_next      = state_reg;
      owner_next      = owner_reg;
      fetch_addr_next = fetch_addr_reg;
      mem_req_next    = mem_req_reg;
      mem_wen_next    = mem_wen_reg;
      mem_size_next   = mem_size_reg;
      mem_addr_next   = mem_addr_reg;
      mem_wdata_next  = mem_wdata_reg;
      case (state_reg)
         ST_IDLE: begin
            if (grant_imem) begin
               owner_next      = OWN_IMEM;
               fetch_addr_next = imem_addr;
               mem_req_next    = 1'b1;
               mem_wen_next    = 1'b0;
               mem_size_next   = SIZE_WORD;
               mem_addr_next   = imem_addr;
               mem_wdata_next  = '0;
               state_next      = ST_REQ;
            end else if (grant_dmem) begin
               owner_next      = OWN_DMEM;
               mem_req_next    = 1'b1;
               mem_wen_next    = dmem_wen;
               mem_size_next   = dmem_size;
               mem_addr_next   = dmem_addr;
               mem_wdata_next  = dmem_wdata;
               state_next      = ST_REQ;
            end
         end
         ST_REQ: begin
            if (mem_ready) begin
               mem_req_next = 1'b0;
               state_next   = ST_RESP;
            end
         end
         ST_RESP: begin
            if (mem_rvalid) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next   = ST_IDLE;
            mem_req_next = 1'b0;
         end
      endcase
   end

   always_comb begin
      streak_next = streak_reg;
      if (!imem_req || grant_imem) begin
         streak_next = '0;
      end else if (grant_dmem && (streak_reg != STREAK_MAX)) begin
         streak_next = streak_reg + STREAK_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg      <= ST_IDLE;
         owner_reg      <= OWN_IMEM;
         fetch_addr_reg <= '0;
         streak_reg     <= '0;
         mem_req_reg    <= 1'b0;
         mem_wen_reg    <= 1'b0;
         mem_size_reg   <= 3'b000;
         mem_addr_reg   <= '0;
         mem_wdata_reg  <= '0;
      end else begin
         state_reg      <= state_next;
         owner_reg      <= owner_next;
         fetch_addr_reg <= fetch_addr_next;
         streak_reg     <= streak_next;
         mem_req_reg    <= mem_req_next;
         mem_wen_reg    <= mem_wen_next;
         mem_size_reg   <= mem_size_next;
         mem_addr_reg   <= mem_addr_next;
         mem_wdata_reg  <= mem_wdata_next;
      end
   end

endmodule

// File: doc/vscale_mem_arbiter.md
# vscale_mem_arbiter

Shares one single-outstanding memory port between the vscale instruction-fetch (imem) and data (dmem) interfaces. It aligns-checks each request, arbitrates with dmem priority plus an anti-starvation limit, sequences the request/response handshake and returns `*_wait`, `*_rdata` and `*_badmem_e` to the core pipeline control. It sits between the core and the external memory/bus adapter.

## Interface
- `ADDR_WIDTH`, 32, address width of all ports
- `DATA_WIDTH`, 32, data width of all ports
- `MAX_DMEM_STREAK`, 4, consecutive dmem grants allowed while imem is waiting (≥1)

- `clk`  in  1  clock; the block uses one clock
- `reset`  in  1  reset, synchronous and active-low
- `imem_req`  in  1  fetch request; held with `imem_addr` while `imem_wait`=1
- `imem_addr`  in  ADDR_WIDTH  fetch address
- `imem_wait`  out  1  fetch not complete this cycle
- `imem_rdata`  out  DATA_WIDTH  fetch data, valid when `imem_req`=1 and `imem_wait`=0
- `imem_badmem_e`  out  1  fetch completed with error (misaligned or bus error)
- `dmem_req`  in  1  data request; held with the other dmem inputs while `dmem_wait`=1
- `dmem_wen`  in  1  1=store
- `dmem_size`  in  3  funct3 encoding; [1:0] 0=byte, 1=half, 2=word, 3=illegal
- `dmem_addr`  in  ADDR_WIDTH  data address
- `dmem_wdata`  in  DATA_WIDTH  store data
- `dmem_wait`  out  1  data access not complete this cycle
- `dmem_rdata`  out  DATA_WIDTH  load data, valid on completion
- `dmem_badmem_e`  out  1  data access completed with error
- `mem_req`  out  1  memory request valid
- `mem_wen`, `mem_size`, `mem_addr`, `mem_wdata`  out  1/3/ADDR_WIDTH/DATA_WIDTH  request fields, stable while `mem_req`=1
- `mem_ready`  in  1  memory accepts request when `mem_req`&&`mem_ready`
- `mem_rvalid`  in  1  response (loads and stores) for the accepted request
- `mem_rdata`  in  DATA_WIDTH  response data
- `mem_error`  in  1  response carries bus error, qualified by `mem_rvalid`

## Operation
- States: IDLE, REQ, RESP. Registers: state, owner (IMEM/DMEM), captured imem address, streak counter (width clog2(MAX_DMEM_STREAK+1)), registered `mem_*` request fields.
- Alignment (combinational, IDLE only): imem bad if addr[1:0]≠0; dmem bad if size[1:0]=3, half with addr[0]=1, or word with addr[1:0]≠0. Bad request completes in the same cycle: `*_wait`=0, `*_badmem_e`=1, no memory transaction, state stays IDLE. If both requesters are bad, both complete that cycle.
- Arbitration (IDLE, aligned requests only): dmem wins unless imem also requests and streak = MAX_DMEM_STREAK, then imem wins. A bad request does not block the other requester's grant in the same cycle.
- Streak: +1 on dmem grant while `imem_req`=1 (saturating); cleared on imem grant or any cycle `imem_req`=0.
- Grant: capture fields into `mem_*`, set owner, go REQ. REQ: `mem_req`=1 until `mem_ready`, then RESP, `mem_req`=0. RESP: on `mem_rvalid` go IDLE.
- Completion: in RESP with `mem_rvalid`, owner's `*_wait`=0, `*_rdata`=`mem_rdata`, `*_badmem_e`=`mem_error` (combinational pass-through).
- Fetch abort: if owner=IMEM and at `mem_rvalid` `imem_req`=0 or `imem_addr`≠captured address, the response is discarded; `imem_wait` stays 1 if requesting; return to IDLE and re-arbitrate next cycle.
- `*_wait` = `*_req` && not completing this cycle. `*_badmem_e`=0 whenever not completing.
- `mem_rvalid` outside RESP is ignored.

## Timing
- Reset (`reset`=0 at posedge): state IDLE, streak 0, `mem_req`=0, `mem_wen`=0, `mem_size`=0, `mem_addr`=0, `mem_wdata`=0. Outputs while in reset/IDLE with no request: `*_wait`=0, `*_badmem_e`=0, `*_rdata`=`mem_rdata`. Reset during REQ/RESP abandons the transaction without completion.
- Grant at cycle N → `mem_req`=1 at N+1. Zero-wait memory (`mem_ready` at N+1, `mem_rvalid` at N+2) → requester `*_wait`=0 at N+2; minimum latency 3 cycles, throughput one access per 3 cycles.
- Misaligned request: completes in cycle of presentation (latency 0).
- `mem_rvalid` in the same cycle as `mem_ready` is not permitted by the memory; not handled.
- Loser of arbitration sees `*_wait`=1 until its own completion.

## Test plan
- Single aligned fetch 0x100, memory zero-wait, `mem_rdata`=0x00000013 → `mem_req` at N+1, `imem_wait`=0 and `imem_rdata`=0x00000013 at N+2, `imem_badmem_e`=0.
- Simultaneous imem 0x200 / dmem load 0x1000 word, imem held, dmem re-requests back-to-back, MAX_DMEM_STREAK=4 → 4 dmem grants, 5th grant imem, streak cleared.
- dmem half store at 0x1001 → `dmem_wait`=0, `dmem_badmem_e`=1 same cycle, `mem_req` never asserted; size[1:0]=3 at 0x1000 likewise.
- Load with `mem_ready` delayed 3 cycles and `mem_error`=1 on response → `mem_req` held 4 cycles with stable fields, `dmem_badmem_e`=1 on completion.
- Fetch 0x300 granted, `imem_addr` changed to 0x400 before `mem_rvalid` → response dropped, `imem_wait` stays 1, new fetch to 0x400 issued, completes with its data.
- `reset`=0 during RESP, then `mem_rvalid` after release → ignored, state IDLE, all `mem_*`=0, no completion.
